// File: rtl/lsu_mem_access.sv
// rtl/lsu_mem_access.sv - multi-cycle load/store unit feeding the LDX load-extension stage
// One transaction at a time: check, issue a lane-aligned memory request, return right-justified bytes.
module lsu_mem_access #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic [31:0] mem_addr,
  output logic [3:0]  mem_we,
  output logic [31:0] mem_wdata,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        resp_valid,
  output logic [31:0] resp_data,
  output logic [2:0]  resp_ldx_sel,
  output logic        resp_err
);

  localparam logic [7:0] TIMEOUT_LIMIT = 8'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, RESP} state_t;

  state_t      state_q, state_d;
  logic [1:0]  off_q, off_d;
  logic [2:0]  f3_q, f3_d;
  logic        we_q, we_d;
  logic [7:0]  cnt_q, cnt_d;

  logic        mem_valid_d;
  logic [31:0] mem_addr_d;
  logic [3:0]  mem_we_d;
  logic [31:0] mem_wdata_d;
  logic        resp_valid_d;
  logic [31:0] resp_data_d;
  logic [2:0]  resp_ldx_sel_d;
  logic        resp_err_d;

  logic        req_legal;
  logic [3:0]  store_mask;
  logic [31:0] rd_shifted;
  logic [31:0] load_data;
  logic [2:0]  load_sel;

  assign req_ready = (state_q == IDLE) && !rst;

  // Alignment and funct3 legality of the request being offered this cycle.
  always_comb begin
    req_legal = 1'b0;
    case (req_funct3)
      3'b000:  req_legal = 1'b1;
      3'b001:  req_legal = ~req_addr[0];
      3'b010:  req_legal = (req_addr[1:0] == 2'b00);
      3'b100:  req_legal = ~req_we;
      3'b101:  req_legal = ~req_we & ~req_addr[0];
      default: req_legal = 1'b0;
    endcase
  end

  always_comb begin
    store_mask = 4'b1111;
    case (req_funct3[1:0])
      2'b00:   store_mask = 4'b0001 << req_addr[1:0];
      2'b01:   store_mask = 4'b0011 << req_addr[1:0];
      default: store_mask = 4'b1111;
    endcase
  end

  assign rd_shifted = mem_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = rd_shifted;
    load_sel  = 3'b000;
    case (f3_q[1:0])
      2'b00:   load_data = {24'h0, rd_shifted[7:0]};
      2'b01:   load_data = {16'h0, rd_shifted[15:0]};
      default: load_data = rd_shifted;
    endcase
    case (f3_q)
      3'b010:  load_sel = 3'b000;
      3'b101:  load_sel = 3'b001;
      3'b001:  load_sel = 3'b010;
      3'b100:  load_sel = 3'b011;
      3'b000:  load_sel = 3'b100;
      default: load_sel = 3'b000;
    endcase
  end

  always_comb begin
    state_d        = state_q;
    off_d          = off_q;
    f3_d           = f3_q;
    we_d           = we_q;
    cnt_d          = cnt_q;
    mem_valid_d    = mem_valid;
    mem_addr_d     = mem_addr;
    mem_we_d       = mem_we;
    mem_wdata_d    = mem_wdata;
    resp_valid_d   = 1'b0;
    resp_data_d    = resp_data;
    resp_ldx_sel_d = resp_ldx_sel;
    resp_err_d     = resp_err;
    case (state_q)
      IDLE: begin
        if (req_valid) begin
          off_d = req_addr[1:0];
          f3_d  = req_funct3;
          we_d  = req_we;
          if (!req_legal) begin
            state_d        = RESP;
            resp_valid_d   = 1'b1;
            resp_data_d    = 32'h0;
            resp_ldx_sel_d = 3'b000;
            resp_err_d     = 1'b1;
          end else begin
            state_d     = REQ;
            mem_valid_d = 1'b1;
            mem_addr_d  = {req_addr[31:2], 2'b00};
            mem_we_d    = req_we ? store_mask : 4'b0000;
            mem_wdata_d = req_we ? (req_wdata << {req_addr[1:0], 3'b000}) : 32'h0;
          end
        end
      end
      REQ: begin
        if (mem_ready) begin
          mem_valid_d = 1'b0;
          if (we_q) begin
            state_d        = RESP;
            resp_valid_d   = 1'b1;
            resp_data_d    = 32'h0;
            resp_ldx_sel_d = 3'b000;
            resp_err_d     = 1'b0;
          end else begin
            state_d = WAIT_R;
            cnt_d   = 8'd0;
          end
        end
      end
      WAIT_R: begin
        cnt_d = cnt_q + 8'd1;
        // A read arriving on the final allowed cycle still counts as success.
        if (mem_rvalid) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_data_d    = load_data;
          resp_ldx_sel_d = load_sel;
          resp_err_d     = 1'b0;
        end else if (cnt_q + 8'd1 == TIMEOUT_LIMIT) begin
          state_d        = RESP;
          resp_valid_d   = 1'b1;
          resp_data_d    = 32'h0;
          resp_ldx_sel_d = 3'b000;
          resp_err_d     = 1'b1;
        end
      end
      RESP: begin
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      off_q        <= 2'b00;
      f3_q         <= 3'b000;
      we_q         <= 1'b0;
      cnt_q        <= 8'd0;
      mem_valid    <= 1'b0;
      mem_addr     <= 32'h0;
      mem_we       <= 4'b0000;
      mem_wdata    <= 32'h0;
      resp_valid   <= 1'b0;
      resp_data    <= 32'h0;
      resp_ldx_sel <= 3'b000;
      resp_err     <= 1'b0;
    end else begin
      state_q      <= state_d;
      off_q        <= off_d;
      f3_q         <= f3_d;
      we_q         <= we_d;
      cnt_q        <= cnt_d;
      mem_valid    <= mem_valid_d;
      mem_addr     <= mem_addr_d;
      mem_we       <= mem_we_d;
      mem_wdata    <= mem_wdata_d;
      resp_valid   <= resp_valid_d;
      resp_data    <= resp_data_d;
      resp_ldx_sel <= resp_ldx_sel_d;
      resp_err     <= resp_err_d;
    end
  end

endmodule
